gray_decode_scheduler: RTL and testbench

Shares one 4-bit Gray-to-binary conversion datapath among four requesters. Each requester presents a Gray word with a valid/ready handshake. The block arbitrates between them, sequences the conversion through a small state machine, and returns the binary result tagged with the requester index on a single valid/ready output port. It sits between the Gray-coded sources (encoder/counter channels) and the downstream consumer of binary values.

---
 rtl/gray_decode_scheduler_pkg.sv | 25 ++
 rtl/gray_decode_scheduler_core.sv | 13 +
 rtl/gray_decode_scheduler.sv | 123 ++++++++++++
 tb/tb_gray_decode_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gray_decode_scheduler_pkg.sv
// Shared types and reference conversion for the Gray decode scheduler.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package gds_pkg;

  localparam int NREQ = 4;
  localparam int W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gray to binary: the MSB passes through, and each lower bit is XORed with the binary bit above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decode_scheduler_core.sv
// Shared Gray-to-binary conversion datapath, used by every requester in turn.
// Latency: purely combinational, no registers.
// Backpressure: none; the scheduler decides when the result is captured.
module gray2bin_core
  import gds_pkg::*;
(
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = gray2bin(gray);

endmodule

// File: rtl/gray_decode_scheduler.sv
// Arbitrates four Gray-word requesters onto one conversion core and returns binary results tagged with the requester index.
// Latency: grant in cycle N, conversion in N+1, out_valid in N+2; with out_ready held high a new grant is possible every 3 cycles.
// Backpressure: DONE holds its result while out_ready is low, and no new grant is made until the result handshake completes.
// Build option GDS_ROUND_ROBIN_EN: when defined, round-robin arbitration; otherwise fixed priority with requester 0 highest.
module gray_decode_scheduler
  import gds_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_gray,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_binary,
  output logic [1:0]        out_id,
  output logic              busy
);

  state_t       state_q, state_d;
  logic [W-1:0] gray_q, bin_q, conv_bin;
  logic [1:0]   id_q;
  logic [1:0]   grant_idx;
  logic         grant_any;
  logic         grant;

`ifdef GDS_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] cand;

  // Round-robin pick: search upward from the pointer and wrap around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The pointer moves past the granted requester, and only when a grant is made.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= grant_idx + 2'd1;
    end
  end
`else
  // Fixed priority: the lowest-numbered valid requester wins, so it is scanned last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = 2'(k);
      end
    end
  end
`endif

  // A grant is only possible in IDLE, and reset overrides it in the same cycle.
  assign grant = (state_q == IDLE) && grant_any && !rst;

  // Next-state logic and the one-hot req_ready.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = CONV;
        end
      end
      CONV:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  gray2bin_core u_core (
    .gray (gray_q),
    .bin  (conv_bin)
  );

  // Capture the granted word and its index, then register the converted value in CONV.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
      id_q   <= '0;
      bin_q  <= '0;
    end else begin
      if (grant) begin
        gray_q <= req_gray[grant_idx*W +: W];
        id_q   <= grant_idx;
      end
      if (state_q == CONV) begin
        bin_q <= conv_bin;
      end
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_binary = bin_q;
  assign out_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gray_decode_scheduler.sv
// Directed bench for gray_decode_scheduler: reset, single request, contention, backpressure,
// exhaustive conversion on requester 3, and reset during CONV and during DONE.
// Expected values are hand-computed constants; outputs are sampled on the falling edge.
module tb_gray_decode_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_binary;
  logic [1:0]  out_id;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Gray code 0..15 mapped to binary, worked out by hand.
  logic [3:0] bin_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                               4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};

  gray_decode_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0] rr_exp;
    logic [3:0] rr_bins [4];
    rr_bins = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};

    rst       = 1'b1;
    req_valid = 4'hF;
    req_gray  = '0;
    out_ready = 1'b0;

    // Reset held for 2 cycles with every requester valid.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_busy",  32'(busy),      32'h0);
    end
    check("rst_bin", 32'(out_binary), 32'h0);
    check("rst_id",  32'(out_id),     32'h0);

    // Single request on requester 2 with Gray 1101.
    rst       = 1'b0;
    req_valid = 4'b0100;
    req_gray  = 16'h0D00;
    out_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    check("single_conv_valid", 32'(out_valid), 32'h0);
    check("single_conv_busy",  32'(busy),      32'h1);
    @(negedge clk);
    check("single_valid", 32'(out_valid),  32'h1);
    check("single_bin",   32'(out_binary), 32'h9);
    check("single_id",    32'(out_id),     32'h2);
    @(negedge clk);
    check("single_release", 32'(out_valid), 32'h0);
    check("single_idle",    32'(busy),      32'h0);

    // One reset cycle to return the pointer to 0, then contention from all four requesters.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'hF;
    req_gray  = 16'hF731;
    for (int g = 0; g < 5; g++) begin
`ifdef GDS_ROUND_ROBIN_EN
      rr_exp = 4'(1 << (g % 4));
`else
      rr_exp = 4'b0001;
`endif
      #1 check("cont_grant", 32'(req_ready), 32'(rr_exp));
      @(negedge clk);
      check("cont_conv_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      check("cont_valid", 32'(out_valid), 32'h1);
`ifdef GDS_ROUND_ROBIN_EN
      check("cont_id",  32'(out_id),     32'(g % 4));
      check("cont_bin", 32'(out_binary), 32'(rr_bins[g % 4]));
`else
      check("cont_id",  32'(out_id),     32'h0);
      check("cont_bin", 32'(out_binary), 32'(rr_bins[0]));
`endif
      if (g == 4) req_valid = 4'b0000;
      @(negedge clk);
    end

    // Backpressure: requester 1 with Gray 1010, consumer stalled for 5 cycles.
    req_valid = 4'b0010;
    req_gray  = 16'h00A0;
    out_ready = 1'b0;
    #1 check("bp_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(out_valid),  32'h1);
      check("bp_bin",   32'(out_binary), 32'hC);
      check("bp_id",    32'(out_id),     32'h1);
      check("bp_ready", 32'(req_ready),  32'h0);
      @(negedge clk);
    end
    check("bp_still_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("bp_release", 32'(out_valid), 32'h0);
    check("bp_idle",    32'(busy),      32'h0);

    // All 16 Gray codes on requester 3.
    for (int g = 0; g < 16; g++) begin
      req_valid = 4'b1000;
      req_gray  = {4'(g), 12'h000};
      #1 check("exh_grant", 32'(req_ready), 32'h8);
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      check("exh_bin", 32'(out_binary), 32'(bin_tbl[g]));
      check("exh_id",  32'(out_id),     32'h3);
      @(negedge clk);
    end

    // Reset while in CONV, after a grant to requester 1.
    req_valid = 4'b0010;
    req_gray  = 16'h0050;
    #1 check("rconv_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1010;
    #1 check("rconv_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("rconv_valid", 32'(out_valid), 32'h0);
    check("rconv_busy",  32'(busy),      32'h0);
    rst = 1'b0;
    #1 check("rconv_regrant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    check("rconv_id",  32'(out_id),     32'h1);
    check("rconv_bin", 32'(out_binary), 32'h6);
    @(negedge clk);

    // Reset while in DONE with a result pending, after a grant to requester 2.
    req_valid = 4'b0100;
    req_gray  = 16'h0F00;
    out_ready = 1'b0;
    #1 check("rdone_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    check("rdone_pending", 32'(out_valid), 32'h1);
    rst       = 1'b1;
    req_valid = 4'b1001;
    req_gray  = 16'h7004;
    @(negedge clk);
    check("rdone_valid", 32'(out_valid), 32'h0);
    check("rdone_busy",  32'(busy),      32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1 check("rdone_regrant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    check("rdone_id",  32'(out_id),     32'h0);
    check("rdone_bin", 32'(out_binary), 32'h7);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
